lsu_mem_master: RTL and testbench

//  Load/store unit: initiator side of the data-memory interface. Accepts one load/store from the core,

---
 rtl/lsu_mem_master.sv | 191 +++++++++++++++++++
 tb/tb_lsu_mem_master.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store unit initiator for a word-addressed req/gnt/rvalid data-memory bus.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned H/W accesses into two beats instead of rejecting them.
module lsu_mem_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [2:0]        load_sel,
  input  logic [1:0]        store_sel,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam logic SPLIT_EN = 1'b1;
`else
  localparam logic SPLIT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t state, state_nxt;

  logic                we_q, split_q;
  logic [1:0]          off_q;
  logic [2:0]          load_sel_q;
  logic [3:0]          be_hi_q;
  logic [DATA_W-1:0]   wdata_hi_q, rdata_lo_q;

  size_t               acc_size;
  logic [1:0]          acc_off;
  logic                acc_noop, acc_misaligned, acc_split, acc_reject;
  logic [3:0]          acc_lanes;
  logic [7:0]          acc_be_wide;
  logic [2*DATA_W-1:0] acc_wdata_wide;

  logic [DATA_W-1:0]   lo_word, hi_word, load_word;
  logic [2*DATA_W-1:0] merged;
  logic [ADDR_W-1:0]   beat1_addr;

  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] w, input logic [2:0] sel);
    case (sel)
      3'b000:  extend = {{(DATA_W-8){w[7]}}, w[7:0]};
      3'b100:  extend = {{(DATA_W-8){1'b0}}, w[7:0]};
      3'b001:  extend = {{(DATA_W-16){w[15]}}, w[15:0]};
      3'b101:  extend = {{(DATA_W-16){1'b0}}, w[15:0]};
      default: extend = w;
    endcase
  endfunction

  // Decode the incoming request: access size, lane pattern and whether it straddles a word.
  always_comb begin
    acc_off  = req_addr[1:0];
    acc_noop = req_we && (store_sel == 2'b11);
    acc_size = SZ_W;
    if (req_we) begin
      case (store_sel)
        2'b00:   acc_size = SZ_B;
        2'b01:   acc_size = SZ_H;
        default: acc_size = SZ_W;
      endcase
    end else begin
      case (load_sel[1:0])
        2'b00:   acc_size = SZ_B;
        2'b01:   acc_size = SZ_H;
        default: acc_size = SZ_W;
      endcase
    end
    case (acc_size)
      SZ_B:    acc_lanes = 4'b0001;
      SZ_H:    acc_lanes = 4'b0011;
      default: acc_lanes = 4'b1111;
    endcase
    acc_misaligned = !acc_noop &&
                     (((acc_size == SZ_H) && (acc_off == 2'b11)) ||
                      ((acc_size == SZ_W) && (acc_off != 2'b00)));
    acc_split      = acc_misaligned && SPLIT_EN;
    acc_reject     = acc_misaligned && !SPLIT_EN;
    acc_be_wide    = {4'b0000, acc_lanes} << acc_off;
    acc_wdata_wide = {{DATA_W{1'b0}}, req_wdata} << {acc_off, 3'b000};
  end

  // Upper half of the 64-bit window only matters for the second beat of a split load.
  always_comb begin
    lo_word = mem_rdata;
    hi_word = '0;
    if (state == WAIT1) begin
      lo_word = rdata_lo_q;
      hi_word = mem_rdata;
    end
    merged    = {hi_word, lo_word} >> {off_q, 3'b000};
    load_word = extend(merged[DATA_W-1:0], load_sel_q);
  end

  assign beat1_addr = mem_addr + ADDR_W'(4);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    mem_req   = (state == REQ0) || (state == REQ1);
    case (state)
      IDLE:    if (req_valid) state_nxt = (acc_noop || acc_reject) ? RESP : REQ0;
      REQ0:    if (mem_gnt) state_nxt = !we_q ? WAIT0 : (split_q ? REQ1 : RESP);
      WAIT0:   if (mem_rvalid) state_nxt = split_q ? REQ1 : RESP;
      REQ1:    if (mem_gnt) state_nxt = we_q ? RESP : WAIT1;
      WAIT1:   if (mem_rvalid) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus fields are loaded at accept and switched to the second beat after beat 0 completes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q       <= 1'b0;
      split_q    <= 1'b0;
      off_q      <= 2'b00;
      load_sel_q <= 3'b000;
      be_hi_q    <= 4'b0000;
      wdata_hi_q <= '0;
      rdata_lo_q <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= 4'b0000;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_q       <= req_we;
          split_q    <= acc_split;
          off_q      <= acc_off;
          load_sel_q <= load_sel;
          rsp_err    <= acc_reject;
          mem_we     <= req_we;
          mem_addr   <= {req_addr[ADDR_W-1:2], 2'b00};
          mem_be     <= acc_be_wide[3:0];
          mem_wdata  <= req_we ? acc_wdata_wide[DATA_W-1:0] : '0;
          be_hi_q    <= acc_be_wide[7:4];
          wdata_hi_q <= req_we ? acc_wdata_wide[2*DATA_W-1:DATA_W] : '0;
          if (acc_noop || acc_reject) rsp_rdata <= '0;
        end
        REQ0: if (mem_gnt && we_q) begin
          if (split_q) begin
            mem_addr  <= beat1_addr;
            mem_be    <= be_hi_q;
            mem_wdata <= wdata_hi_q;
          end else begin
            rsp_rdata <= '0;
          end
        end
        WAIT0: if (mem_rvalid) begin
          rdata_lo_q <= mem_rdata;
          if (split_q) begin
            mem_addr <= beat1_addr;
            mem_be   <= be_hi_q;
          end else begin
            rsp_rdata <= load_word;
          end
        end
        REQ1:  if (mem_gnt && we_q) rsp_rdata <= '0;
        WAIT1: if (mem_rvalid) rsp_rdata <= load_word;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed self-checking bench for lsu_mem_master with a small word memory responder.
// Expectations for misaligned accesses follow LSU_MISALIGN_SPLIT_EN when it is defined.
module tb_lsu_mem_master;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  load_sel;
  logic [1:0]  store_sel;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic [31:0] mem [0:255];
  int          n_compared = 0;
  int          n_mismatched = 0;
  int          cyc = 0, acc_cyc = 0, rsp_cyc = 0;
  int          rsp_count = 0, rsp_base = 0;
  int          req_cycles = 0, req_base = 0;
  int          beats = 0;
  int          stall_left = 0, rvalid_lat = 1, pend_cnt = 0;
  logic [31:0] pend_addr;
  logic [31:0] g_addr [0:3];
  logic [3:0]  g_be   [0:3];
  logic [31:0] g_wdata[0:3];

  lsu_mem_master dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .load_sel(load_sel), .store_sel(store_sel),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    assert (observed === expected)
      else begin
        n_mismatched++;
        $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
  endtask

  // One clock: record the handshake at this edge, then drive the responder for the next cycle.
  task automatic tick();
    logic rd_hs;
    rd_hs = mem_req && mem_gnt && !mem_we;
    if (mem_req && mem_gnt) begin
      if (beats < 4) begin
        g_addr[beats]  = mem_addr;
        g_be[beats]    = mem_be;
        g_wdata[beats] = mem_wdata;
      end
      beats++;
      if (mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
    end
    if (rd_hs) begin
      pend_cnt  = rvalid_lat;
      pend_addr = mem_addr;
    end
    @(posedge clk);
    #1;
    cyc++;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'hDEADBEEF;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem[pend_addr[9:2]];
      end
    end
    if (mem_req) begin
      req_cycles++;
      if (stall_left > 0) begin
        stall_left--;
        mem_gnt = 1'b0;
      end else begin
        mem_gnt = 1'b1;
      end
    end else begin
      mem_gnt = 1'b0;
    end
    if (rsp_valid) begin
      rsp_count++;
      rsp_cyc = cyc;
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [2:0] lsel, input logic [1:0] ssel);
    int n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    checkOutput("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    load_sel  = lsel;
    store_sel = ssel;
    beats     = 0;
    rsp_base  = rsp_count;
    req_base  = req_cycles;
    acc_cyc   = cyc;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic waitRsp(input string tag, input int max_cycles);
    int n = 0;
    while (rsp_count == rsp_base && n < max_cycles) begin
      tick();
      n++;
    end
    checkOutput({tag, "_rsp_seen"}, 32'(rsp_count != rsp_base), 32'd1);
  endtask

  task automatic endTxn(input string tag);
    tick();
    checkOutput({tag, "_pulses"}, 32'(rsp_count - rsp_base), 32'd1);
    checkOutput({tag, "_rsp_low"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    load_sel = 3'b000; store_sel = 2'b00; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    tick();
    tick();
    checkOutput("rst_ready",     32'(req_ready), 32'd1);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_err",   32'(rsp_err),   32'd0);
    checkOutput("rst_mem_req",   32'(mem_req),   32'd0);
    checkOutput("rst_mem_we",    32'(mem_we),    32'd0);
    checkOutput("rst_rsp_rdata", rsp_rdata,      32'h0);
    checkOutput("rst_mem_addr",  mem_addr,       32'h0);
    checkOutput("rst_mem_be",    32'(mem_be),    32'h0);
    checkOutput("rst_mem_wdata", mem_wdata,      32'h0);
    rst_n = 1'b1;
    tick();

    $display("[TB] LB / LBU / LH on 0x8899AABB");
    mem[64] = 32'h8899AABB;
    applyStimulus(1'b0, 32'h101, 32'h0, 3'b000, 2'b00);
    checkOutput("lb_mem_req",  32'(mem_req), 32'd1);
    checkOutput("lb_mem_addr", mem_addr, 32'h100);
    checkOutput("lb_mem_be",   32'(mem_be), 32'h2);
    checkOutput("lb_mem_we",   32'(mem_we), 32'd0);
    checkOutput("lb_busy",     32'(req_ready), 32'd0);
    waitRsp("lb", 20);
    checkOutput("lb_latency", 32'(rsp_cyc - acc_cyc), 32'd3);
    checkOutput("lb_rdata",   rsp_rdata, 32'hFFFFFFAA);
    checkOutput("lb_err",     32'(rsp_err), 32'd0);
    endTxn("lb");

    applyStimulus(1'b0, 32'h101, 32'h0, 3'b100, 2'b00);
    waitRsp("lbu", 20);
    checkOutput("lbu_rdata", rsp_rdata, 32'h000000AA);
    endTxn("lbu");

    applyStimulus(1'b0, 32'h102, 32'h0, 3'b001, 2'b00);
    waitRsp("lh", 20);
    checkOutput("lh_rdata", rsp_rdata, 32'hFFFF8899);
    checkOutput("lh_be",    32'(g_be[0]), 32'hC);
    endTxn("lh");

    $display("[TB] SH 0x102 with grant withheld three cycles");
    stall_left = 3;
    applyStimulus(1'b1, 32'h102, 32'h00001234, 3'b000, 2'b01);
    for (int i = 0; i < 3; i++) begin
      checkOutput("sh_stall_req",   32'(mem_req), 32'd1);
      checkOutput("sh_stall_gnt",   32'(mem_gnt), 32'd0);
      checkOutput("sh_stall_addr",  mem_addr, 32'h100);
      checkOutput("sh_stall_be",    32'(mem_be), 32'hC);
      checkOutput("sh_stall_wdata", mem_wdata, 32'h12340000);
      checkOutput("sh_stall_we",    32'(mem_we), 32'd1);
      checkOutput("sh_stall_ready", 32'(req_ready), 32'd0);
      tick();
    end
    waitRsp("sh", 20);
    checkOutput("sh_err",   32'(rsp_err), 32'd0);
    checkOutput("sh_rdata", rsp_rdata, 32'h0);
    checkOutput("sh_beats", 32'(beats), 32'd1);
    checkOutput("sh_mem",   mem[64], 32'h1234AABB);
    endTxn("sh");
    checkOutput("sh_req_dropped", 32'(mem_req), 32'd0);

    $display("[TB] store_sel=11 no-op");
    applyStimulus(1'b1, 32'h100, 32'hFFFFFFFF, 3'b000, 2'b11);
    checkOutput("noop_rsp_now", 32'(rsp_valid), 32'd1);
    checkOutput("noop_err",     32'(rsp_err), 32'd0);
    checkOutput("noop_no_req",  32'(req_cycles - req_base), 32'd0);
    endTxn("noop");
    checkOutput("noop_mem", mem[64], 32'h1234AABB);

    $display("[TB] aligned and misaligned LW");
    mem[64] = 32'h44332211;
    mem[65] = 32'h88776655;
    applyStimulus(1'b0, 32'h104, 32'h0, 3'b010, 2'b00);
    waitRsp("lw", 20);
    checkOutput("lw_rdata", rsp_rdata, 32'h88776655);
    checkOutput("lw_addr",  g_addr[0], 32'h104);
    checkOutput("lw_be",    32'(g_be[0]), 32'hF);
    endTxn("lw");

    applyStimulus(1'b0, 32'h103, 32'h0, 3'b010, 2'b00);
`ifdef LSU_MISALIGN_SPLIT_EN
    waitRsp("lwm", 30);
    checkOutput("lwm_beats",  32'(beats), 32'd2);
    checkOutput("lwm_addr0",  g_addr[0], 32'h100);
    checkOutput("lwm_be0",    32'(g_be[0]), 32'h8);
    checkOutput("lwm_addr1",  g_addr[1], 32'h104);
    checkOutput("lwm_be1",    32'(g_be[1]), 32'h7);
    checkOutput("lwm_rdata",  rsp_rdata, 32'h77665544);
    checkOutput("lwm_err",    32'(rsp_err), 32'd0);
`else
    checkOutput("lwm_rsp_now", 32'(rsp_valid), 32'd1);
    checkOutput("lwm_err",     32'(rsp_err), 32'd1);
    checkOutput("lwm_rdata",   rsp_rdata, 32'h0);
    checkOutput("lwm_no_req",  32'(req_cycles - req_base), 32'd0);
`endif
    endTxn("lwm");

    $display("[TB] misaligned SW 0x101");
    applyStimulus(1'b1, 32'h101, 32'hAABBCCDD, 3'b000, 2'b10);
`ifdef LSU_MISALIGN_SPLIT_EN
    waitRsp("swm", 30);
    checkOutput("swm_beats",  32'(beats), 32'd2);
    checkOutput("swm_be0",    32'(g_be[0]), 32'hE);
    checkOutput("swm_wdata0", g_wdata[0], 32'hBBCCDD00);
    checkOutput("swm_addr1",  g_addr[1], 32'h104);
    checkOutput("swm_be1",    32'(g_be[1]), 32'h1);
    checkOutput("swm_wdata1", g_wdata[1], 32'h000000AA);
    checkOutput("swm_err",    32'(rsp_err), 32'd0);
    endTxn("swm");
    checkOutput("swm_mem0",   mem[64], 32'hBBCCDD11);
    checkOutput("swm_mem1",   mem[65], 32'h887766AA);
`else
    checkOutput("swm_rsp_now", 32'(rsp_valid), 32'd1);
    checkOutput("swm_err",     32'(rsp_err), 32'd1);
    checkOutput("swm_no_req",  32'(req_cycles - req_base), 32'd0);
    endTxn("swm");
    checkOutput("swm_mem0",    mem[64], 32'h44332211);
`endif

    $display("[TB] LW 0xFFFFFFFE address wrap");
    mem[255] = 32'h11223344;
    mem[0]   = 32'h55667788;
    applyStimulus(1'b0, 32'hFFFFFFFE, 32'h0, 3'b010, 2'b00);
`ifdef LSU_MISALIGN_SPLIT_EN
    waitRsp("wrap", 30);
    checkOutput("wrap_addr0", g_addr[0], 32'hFFFFFFFC);
    checkOutput("wrap_addr1", g_addr[1], 32'h0);
    checkOutput("wrap_be1",   32'(g_be[1]), 32'h3);
    checkOutput("wrap_rdata", rsp_rdata, 32'h77881122);
`else
    checkOutput("wrap_err",    32'(rsp_err), 32'd1);
    checkOutput("wrap_rdata",  rsp_rdata, 32'h0);
    checkOutput("wrap_no_req", 32'(req_cycles - req_base), 32'd0);
`endif
    endTxn("wrap");

    $display("[TB] reset while waiting for read data");
    rvalid_lat = 3;
    applyStimulus(1'b0, 32'h100, 32'h0, 3'b010, 2'b00);
    tick();
    checkOutput("rstw_busy", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("rstw_ready", 32'(req_ready), 32'd1);
    tick();
    checkOutput("rstw_rvalid_late", 32'(mem_rvalid), 32'd1);
    tick();
    tick();
    checkOutput("rstw_no_rsp",  32'(rsp_count - rsp_base), 32'd0);
    checkOutput("rstw_ready2",  32'(req_ready), 32'd1);
    checkOutput("rstw_mem_req", 32'(mem_req), 32'd0);
    rvalid_lat = 1;

    $display("[TB] LHU 0x101 after reset");
    mem[64] = 32'h44332211;
    applyStimulus(1'b0, 32'h101, 32'h0, 3'b101, 2'b00);
    waitRsp("lhu", 20);
    checkOutput("lhu_be",    32'(g_be[0]), 32'h6);
    checkOutput("lhu_rdata", rsp_rdata, 32'h00003322);
    checkOutput("lhu_err",   32'(rsp_err), 32'd0);
    endTxn("lhu");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
